// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Op codes match the mdop field driven by the control unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_unit_signfix.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and result sign fix-up.
module md_unit_signfix #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit holding HI/LO.
// MULT/DIV take WIDTH+1 cycles; MTHI/MTLO complete in one.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rsgn_q, rsgn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_sgn;
  logic             op_div;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op_sgn = (mdop == MD_MULT) || (mdop == MD_DIV);
  assign op_div = (mdop == MD_DIV) || (mdop == MD_DIVU);

  md_unit_signfix #(.W(WIDTH)) u_abs_a (
    .neg_i (op_sgn & a[WIDTH-1]),
    .in_i  (a),
    .out_o (a_abs)
  );

  md_unit_signfix #(.W(WIDTH)) u_abs_b (
    .neg_i (op_sgn & b[WIDTH-1]),
    .in_i  (b),
    .out_o (b_abs)
  );

  md_unit_signfix #(.W(2*WIDTH)) u_fix_p (
    .neg_i (neg_q),
    .in_i  ({acc_hi_q, acc_lo_q}),
    .out_o (prod_fix)
  );

  md_unit_signfix #(.W(WIDTH)) u_fix_q (
    .neg_i (neg_q),
    .in_i  (acc_lo_q),
    .out_o (quo_fix)
  );

  md_unit_signfix #(.W(WIDTH)) u_fix_r (
    .neg_i (rsgn_q),
    .in_i  (acc_hi_q),
    .out_o (rem_fix)
  );

  // acc_lo holds the multiplier (mul) or dividend/quotient (div)
  assign mul_sum  = {1'b0, acc_hi_q}
                  + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rsgn_d   = rsgn_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (mdop)
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d  = S_RUN;
              cnt_d    = '0;
              busy_d   = 1'b1;
              is_div_d = op_div;
              acc_hi_d = '0;
              acc_lo_d = op_div ? a_abs : b_abs;
              opnd_d   = op_div ? b_abs : a_abs;
              // divide-by-zero keeps an all-ones quotient unsigned
              neg_d    = op_sgn & (a[WIDTH-1] ^ b[WIDTH-1])
                       & ~(op_div & (b == '0));
              rsgn_d   = op_sgn & a[WIDTH-1];
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_hi_d = div_diff[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_d = div_sh[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = S_FIX;
            done_d  = 1'b1;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rsgn_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rsgn_q   <= rsgn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table plus
// hand-written sequences for MTHI/MTLO, flush and reset.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  md_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mdop  (mdop),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // start at negedge, sampled at next posedge
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] av,
                       input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    mdop  = MD_NONE;
  endtask

  task automatic wait_idle(output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      nb++;
      if (done) nd++;
      @(negedge clk);
    end
  endtask

  int nb, nd;

  initial begin
    v[0]  = '{MD_MULTU, 32'd7,        32'd6,        32'h0,        32'd42};
    v[1]  = '{MD_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
    v[2]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE};
    v[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    v[5]  = '{MD_DIVU,  32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF};
    v[6]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD};
    v[7]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    v[8]  = '{MD_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    v[9]  = '{MD_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0,        32'd15};
    v[10] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};

    rst_n = 1'b0;
    start = 1'b0;
    mdop  = MD_NONE;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);

    for (int i = 0; i < 11; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_idle(nb, nd);
      chk($sformatf("v%0d busy", i), 32'(nb), 32'd33);
      chk($sformatf("v%0d done", i), 32'(nd), 32'd1);
      chk($sformatf("v%0d hi", i), hi, v[i].hi);
      chk($sformatf("v%0d lo", i), lo, v[i].lo);
    end

    // MTHI / MTLO: single edge, never busy
    issue(MD_MTHI, 32'hA5A5A5A5, 32'h0);
    chk("mthi hi", hi, 32'hA5A5A5A5);
    chk("mthi busy", 32'(busy), 32'd0);
    chk("mthi done", 32'(done), 32'd0);
    issue(MD_MTLO, 32'h5A5A5A5A, 32'h0);
    chk("mtlo lo", lo, 32'h5A5A5A5A);
    chk("mtlo hi", hi, 32'hA5A5A5A5);

    // second start mid-run must be ignored
    issue(MD_MULT, 32'd3, 32'd4);
    nb = 0;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      nb++;
      if (done) nd++;
      if (i == 10) begin
        start = 1'b1;
        mdop  = MD_MULTU;
        a     = 32'd100;
        b     = 32'd100;
      end else begin
        start = 1'b0;
        mdop  = MD_NONE;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mdop  = MD_NONE;
    chk("mid busy", 32'(nb), 32'd33);
    chk("mid done", 32'(nd), 32'd1);
    chk("mid hi", hi, 32'h0);
    chk("mid lo", lo, 32'd12);
    repeat (3) @(negedge clk);
    chk("mid idle", 32'(busy), 32'd0);

    // flush in RUN: abort, keep HI/LO
    issue(MD_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    chk("fl busy pre", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl busy", 32'(busy), 32'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("fl done", 32'(nd), 32'd0);
    chk("fl hi", hi, 32'h0);
    chk("fl lo", lo, 32'd12);

    // flush beats start in IDLE
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    mdop  = MD_MTHI;
    a     = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    mdop  = MD_NONE;
    chk("flst hi", hi, 32'h0);
    chk("flst busy", 32'(busy), 32'd0);

    // async reset mid-run
    issue(MD_MULTU, 32'd7, 32'd6);
    repeat (5) @(negedge clk);
    chk("rr busy pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr busy", 32'(busy), 32'd0);
    chk("rr hi", hi, 32'h0);
    chk("rr lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rr stay", 32'(busy), 32'd0);
    chk("rr lo2", lo, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
